// File: rtl/booth_pkg.sv
// Shared definitions for the radix-2 Booth multiplier controller:
// FSM states, default operand width and Booth pair encodings.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int BOOTH_WIDTH = 8;
    localparam int CNT_W       = $clog2(BOOTH_WIDTH + 1);

    // {Q[0], q_m1} pairs that touch the accumulator; 00/11 leave A unchanged.
    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_addsub.sv
// N-bit ripple add/subtract: sum = a + (b ^ {N{sub}}) + sub.
// The carry out of the top bit is dropped.
module booth_addsub #(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] sum
);

    always_comb begin
        logic c;
        logic bx;
        c   = sub;
        sum = '0;
        for (int i = 0; i < N; i++) begin
            bx     = b[i] ^ sub;
            sum[i] = a[i] ^ bx ^ c;
            c      = (a[i] & bx) | (c & (a[i] ^ bx));
        end
    end

endmodule

// File: rtl/booth_mult_ctrl.sv
// Sequential radix-2 Booth multiplier controller: one add/sub plus
// arithmetic shift per clock, WIDTH iterations per signed product.
module booth_mult_ctrl
    import booth_pkg::*;
#(
    parameter int WIDTH = BOOTH_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic [1:0]         dbg_state_o
);

    localparam int CW = $clog2(WIDTH + 1);

    // Handshake: a request is taken on a rising edge where start=1 and
    // ready=1; start at any other time is ignored and never queued.

    state_t             state_q, state_d;
    logic [WIDTH:0]     a_q, a_d;
    logic [WIDTH:0]     m_q;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               qm1_q, qm1_d;
    logic [CW-1:0]      count_q;
    logic               busy_q, done_q;
    logic [2*WIDTH-1:0] product_q;

    logic           load, step, last;
    logic [1:0]     pair;
    logic [WIDTH:0] sum, a_sel;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (count_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign last = step && (count_q == CW'(1));
    assign pair = {q_q[0], qm1_q};

    booth_addsub #(.N(WIDTH + 1)) u_addsub (
        .a   (a_q),
        .b   (m_q),
        .sub (pair == BOOTH_SUB),
        .sum (sum)
    );

    assign a_sel = (pair == BOOTH_ADD || pair == BOOTH_SUB) ? sum : a_q;

    // Arithmetic shift of {A, Q, q_m1}, replicating A's sign bit.
    assign a_d   = {a_sel[WIDTH], a_sel[WIDTH:1]};
    assign q_d   = {a_sel[0], q_q[WIDTH-1:1]};
    assign qm1_d = q_q[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            m_q       <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == RUN);
            done_q  <= last;
            if (load) begin
                a_q     <= '0;
                m_q     <= {multiplicand[WIDTH-1], multiplicand};
                q_q     <= multiplier;
                qm1_q   <= 1'b0;
                count_q <= CW'(WIDTH);
            end else if (step) begin
                a_q     <= a_d;
                q_q     <= q_d;
                qm1_q   <= qm1_d;
                count_q <= count_q - CW'(1);
                if (last) begin
                    product_q <= {a_d[WIDTH-1:0], q_d};
                end
            end
        end
    end

    assign ready       = (state_q == IDLE) || (state_q == DONE);
    assign busy        = busy_q;
    assign done        = done_q;
    assign product     = product_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_booth_mult_ctrl.sv
// Self-checking bench for booth_mult_ctrl: directed corner cases plus
// random operands compared against a plain signed-multiply model.
module tb_booth_mult_ctrl;
    import booth_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  mcand, mplier;
    logic        ready, busy, done;
    logic [15:0] product;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] last_product;

    booth_mult_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (mcand),
        .multiplier   (mplier),
        .ready        (ready),
        .busy         (busy),
        .done         (done),
        .product      (product),
        .dbg_state_o  (dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] ref_mult(input logic [7:0] a, input logic [7:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        return p[15:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Drive a request so it is taken on the next rising edge (E0), then
    // scramble the operand inputs.
    task automatic accept(input logic [7:0] m, input logic [7:0] q);
        start  = 1'b1;
        mcand  = m;
        mplier = q;
        exp_q.push_back(ref_mult(m, q));
        @(posedge clk); #1;
        start  = 1'b0;
        mcand  = 8'($urandom);
        mplier = 8'($urandom);
        check("accept_busy", 32'(busy), 32'd1);
        check("accept_ready", 32'(ready), 32'd0);
        check("accept_done", 32'(done), 32'd0);
        check("accept_hold", 32'(product), 32'(last_product));
    endtask

    // Wait for done; optionally pulse start with other operands before edge pulse_at.
    task automatic wait_done(input string tag, input int pulse_at);
        logic [15:0] exp_v;
        bit got;
        got = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (k == pulse_at) begin
                start  = 1'b1;
                mcand  = 8'($urandom);
                mplier = 8'($urandom);
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
                check({tag, "_latency"}, 32'(k), 32'd8);
                check({tag, "_product"}, 32'(product), 32'(exp_v));
                check({tag, "_busy_end"}, 32'(busy), 32'd0);
                check({tag, "_ready_done"}, 32'(ready), 32'd1);
                last_product = exp_v;
                got = 1'b1;
                break;
            end else begin
                check({tag, "_busy_run"}, 32'(busy), 32'd1);
                check({tag, "_hold"}, 32'(product), 32'(last_product));
            end
        end
        if (!got) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic expect_idle(input string tag);
        @(posedge clk); #1;
        check({tag, "_done_fall"}, 32'(done), 32'd0);
        check({tag, "_ready"}, 32'(ready), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
        check({tag, "_hold"}, 32'(product), 32'(last_product));
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        mcand        = '0;
        mplier       = '0;
        last_product = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_product", 32'(product), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        rst_n = 1'b1;
        @(posedge clk); #1;

        accept(8'd7, 8'd3);
        wait_done("7x3", 0);
        check("7x3_const", 32'(last_product), 32'h0015);
        expect_idle("7x3");

        accept(8'hFB, 8'h03);
        wait_done("m5x3", 0);
        check("m5x3_const", 32'(product), 32'hFFF1);
        expect_idle("m5x3");

        accept(8'h7F, 8'h80);
        wait_done("127xm128", 0);
        check("127xm128_const", 32'(product), 32'hC080);
        expect_idle("127xm128");

        accept(8'h80, 8'h80);
        wait_done("m128sq", 0);
        check("m128sq_const", 32'(product), 32'h4000);
        expect_idle("m128sq");

        accept(8'h12, 8'hE7);
        wait_done("ignore_e3", 3);
        expect_idle("ignore_e3");

        accept(8'd2, 8'd2);
        wait_done("b2b_first", 0);
        check("b2b_first_const", 32'(product), 32'h0004);
        accept(8'hFF, 8'hFF);
        wait_done("b2b_second", 0);
        check("b2b_second_const", 32'(product), 32'h0001);
        expect_idle("b2b");

        accept(8'd9, 8'd11);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        last_product = '0;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_product", 32'(product), 32'd0);
        check("abort_state", 32'(dbg_state), 32'(IDLE));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("abort_no_done", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("post_abort_no_done", 32'(done), 32'd0);
        end
        accept(8'hC3, 8'h5A);
        wait_done("post_abort", 0);
        expect_idle("post_abort");

        for (int i = 0; i < 12; i++) begin
            accept(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            wait_done("rand", 0);
            if ($urandom_range(0, 1) == 1) expect_idle("rand");
        end
        expect_idle("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
